// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch-side lookup is combinational on pc_if. Training comes from EX-stage
// resolution. A sweep FSM clears valid/ctr one entry per cycle after reset
// and on invalidate_all.
module btb_predictor #(
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        predicted_taken_if,
    output logic [31:0] predicted_target_if,
    input  logic        update_btb_ex,
    input  logic [31:0] pc_ex,
    input  logic        ex_branch_taken,
    input  logic [31:0] jump_addr_ex,
    input  logic        invalidate_all,
    output logic        btb_ready
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   sweep_idx_q;
    logic               ready_q;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0]   idx_if;
    logic [TAG_W-1:0]   tag_if;
    logic               hit_if;
    logic [IDX_W-1:0]   idx_ex;
    logic [TAG_W-1:0]   tag_ex;
    logic               hit_ex;
    logic               sweep_en;
    logic               upd_en;
    logic               unused_addr_bits;

    // Byte offset within a word never selects an entry.
    assign unused_addr_bits = ^{pc_if[1:0], pc_ex[1:0]};

    assign idx_if = pc_if[IDX_W+1:2];
    assign tag_if = pc_if[31:IDX_W+2];
    assign idx_ex = pc_ex[IDX_W+1:2];
    assign tag_ex = pc_ex[31:IDX_W+2];

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign hit_if              = ready_q && valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign predicted_taken_if  = hit_if && ctr_q[idx_if][1];
    assign predicted_target_if = predicted_taken_if ? target_q[idx_if] : (pc_if + 32'd4);
    assign btb_ready           = ready_q;

    assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

    // invalidate_all and reset both pre-empt any table write in the same cycle.
    assign sweep_en = rst_n && !invalidate_all && (state_q == INIT);
    assign upd_en   = rst_n && !invalidate_all && (state_q == RUN) && update_btb_ex;

    // Sweep FSM: INIT walks every index once, then hands over to RUN.
    always_ff @(posedge clk) begin
        if (!rst_n || invalidate_all) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    sweep_idx_q <= sweep_idx_q + IDX_W'(1);
                    if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= INIT;
                    sweep_idx_q <= '0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    // Table storage: sweep clears valid/ctr; training adjusts counters and allocates.
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            valid_q[sweep_idx_q] <= 1'b0;
            ctr_q[sweep_idx_q]   <= 2'b00;
        end else if (upd_en) begin
            if (hit_ex) begin
                if (ex_branch_taken) begin
                    ctr_q[idx_ex]    <= (ctr_q[idx_ex] == 2'b11) ? 2'b11 : ctr_q[idx_ex] + 2'd1;
                    target_q[idx_ex] <= jump_addr_ex;
                end else begin
                    ctr_q[idx_ex] <= (ctr_q[idx_ex] == 2'b00) ? 2'b00 : ctr_q[idx_ex] - 2'd1;
                end
            end else if (ex_branch_taken) begin
                valid_q[idx_ex]  <= 1'b1;
                tag_q[idx_ex]    <= tag_ex;
                target_q[idx_ex] <= jump_addr_ex;
                ctr_q[idx_ex]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor with ENTRIES=16.
module tb_btb_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        predicted_taken_if;
    logic [31:0] predicted_target_if;
    logic        update_btb_ex;
    logic [31:0] pc_ex;
    logic        ex_branch_taken;
    logic [31:0] jump_addr_ex;
    logic        invalidate_all;
    logic        btb_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    btb_predictor #(.ENTRIES(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_if               (pc_if),
        .predicted_taken_if  (predicted_taken_if),
        .predicted_target_if (predicted_target_if),
        .update_btb_ex       (update_btb_ex),
        .pc_ex               (pc_ex),
        .ex_branch_taken     (ex_branch_taken),
        .jump_addr_ex        (jump_addr_ex),
        .invalidate_all      (invalidate_all),
        .btb_ready           (btb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Look up pc and compare both prediction outputs.
    task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        pc_if = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, predicted_taken_if}, {31'd0, pt});
        chk({tag, "_target"}, predicted_target_if, tgt);
    endtask

    // One EX update, applied at the next edge.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] jmp);
        update_btb_ex   = 1'b1;
        pc_ex           = pc;
        ex_branch_taken = taken;
        jump_addr_ex    = jmp;
        tick();
        update_btb_ex   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pc_if = 32'h100; update_btb_ex = 1'b0; pc_ex = '0;
        ex_branch_taken = 1'b0; jump_addr_ex = '0; invalidate_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset sweep: ready low for 16 cycles, high after the 16th edge.
        #1;
        chk("rst_ready0", {31'd0, btb_ready}, 32'd0);
        look("rst_lookup", 32'h100, 1'b0, 32'h104);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("rst_ready_k%0d", k), {31'd0, btb_ready}, (k == 16) ? 32'd1 : 32'd0);
        end
        look("run_empty", 32'h100, 1'b0, 32'h104);

        // Allocation, with the same-cycle lookup seeing old contents.
        update_btb_ex = 1'b1; pc_ex = 32'h100; ex_branch_taken = 1'b1; jump_addr_ex = 32'h200;
        look("alloc_same_cycle", 32'h100, 1'b0, 32'h104);
        tick();
        update_btb_ex = 1'b0;
        look("alloc_next", 32'h100, 1'b1, 32'h200);

        // Training: 2 -> 3 -> 3 -> 3, then down to 0 and floor.
        for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 32'h200);
        look("sat_hi", 32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0);
        look("nt1_ctr2", 32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0);
        look("nt2_ctr1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        look("floor_ctr0", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h220);
        look("floor_then_t_ctr1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h240);
        look("ctr2_new_target", 32'h100, 1'b1, 32'h240);

        // Aliasing at index 0: 0x140 shares the slot with 0x100.
        upd(32'h140, 1'b0, 32'h300);
        look("alias_nt_keep", 32'h100, 1'b1, 32'h240);
        look("alias_nt_miss", 32'h140, 1'b0, 32'h144);
        upd(32'h140, 1'b1, 32'h300);
        look("alias_old_evicted", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 32'h300);

        // Install a second entry elsewhere so the sweep has two to clear.
        upd(32'h184, 1'b1, 32'h700);
        look("idx1_alloc", 32'h184, 1'b1, 32'h700);

        // Invalidate together with an update that must be dropped.
        invalidate_all = 1'b1;
        update_btb_ex = 1'b1; pc_ex = 32'h180; ex_branch_taken = 1'b1; jump_addr_ex = 32'h400;
        tick();
        invalidate_all = 1'b0;
        update_btb_ex  = 1'b0;
        chk("inv_ready_k0", {31'd0, btb_ready}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                update_btb_ex = 1'b1; pc_ex = 32'h100; ex_branch_taken = 1'b1; jump_addr_ex = 32'h500;
            end
            tick();
            update_btb_ex = 1'b0;
            chk($sformatf("inv_ready_k%0d", k), {31'd0, btb_ready}, (k == 16) ? 32'd1 : 32'd0);
        end
        look("inv_miss_100", 32'h100, 1'b0, 32'h104);
        look("inv_miss_180", 32'h180, 1'b0, 32'h184);
        look("inv_miss_140", 32'h140, 1'b0, 32'h144);
        look("inv_miss_184", 32'h184, 1'b0, 32'h188);

        // Fresh allocation after the sweep starts again at ctr=2.
        upd(32'h100, 1'b1, 32'h600);
        look("realloc", 32'h100, 1'b1, 32'h600);
        look("byte_offset_ignored", 32'h102, 1'b1, 32'h600);

        // Fall-through add wraps.
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Reset while running restarts the sweep.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rerst_ready", {31'd0, btb_ready}, 32'd0);
        look("rerst_lookup", 32'h100, 1'b0, 32'h104);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
